load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, data/address width.
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low (0 = reset).
REQ-004 SHALL have port: req_valid  input  1  core presents a load/store this cycle.
REQ-005 SHALL have port: req_ready  output  1  unit idle and accepting a request.
REQ-006 SHALL have port: is_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: funct3  input  3  access size/sign (RV32I encoding).
REQ-008 SHALL have port: base  input  XLEN  rs1 value; offset  input  XLEN  sign-extended immediate.
REQ-009 SHALL have port: store_data  input  XLEN  rs2 value; rd  input  5  load destination.
REQ-010 SHALL have port: mem_valid  output  1  memory request pending; mem_ready  input  1  memory completes the request this cycle.
REQ-011 SHALL have port: mem_addr  output  XLEN  word-aligned address; mem_we  output  1; mem_wstrb  output  4; mem_wdata  output  32.
REQ-012 SHALL have port: mem_rdata  input  32  read word, valid in the mem_ready cycle.
REQ-013 SHALL have port: wb_enable  output  1; wb_reg  output  5; wb_data  output  XLEN  register-file write port drive.
REQ-014 SHALL have port: fault  output  1  one-cycle pulse for misaligned or illegal request.

Function
REQ-015 SHALL implement FSM states IDLE, MEM, WB; req_ready = (state == IDLE).
REQ-016 Accept = req_valid & req_ready; SHALL register ea = base + offset (mod 2^32), funct3, is_store, rd, store_data on accept.
REQ-017 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; anything else illegal.
REQ-018 Misaligned: halfword with ea[0]=1, word with ea[1:0]!=0; bytes never misaligned.
REQ-019 Illegal or misaligned accept: fault=1 next cycle for exactly one cycle, no mem_valid, no wb_enable, state stays IDLE.
REQ-020 Legal accept: IDLE->MEM; mem_valid=1 from the cycle after accept, held with mem_addr/mem_we/mem_wstrb/mem_wdata stable until the mem_ready cycle.
REQ-021 mem_addr = {ea[31:2], 2'b00}; mem_we = stored is_store.
REQ-022 Store strobes: SB 4'b0001 << ea[1:0]; SH 4'b0011 << ea[1:0]; SW 4'b1111; mem_wdata = store byte/half replicated across all lanes (SB {4{b}}, SH {2{h}}).
REQ-023 Loads: mem_wstrb = 0, mem_wdata = 0.
REQ-024 MEM with mem_ready=1: store -> IDLE; load -> WB, capturing extracted lane of mem_rdata selected by ea[1:0].
REQ-025 Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
REQ-026 WB lasts exactly one cycle: wb_enable=1 (0 if rd==0), wb_reg=rd, wb_data=loaded value; then IDLE.
REQ-027 wb_enable SHALL be 0 in all states except WB; wb_reg/wb_data hold last value otherwise.
REQ-028 Minimum load latency: accept N, mem_valid N+1, mem_ready N+1 -> wb_enable N+2; store with same timing frees unit at N+2.
REQ-029 mem_ready while mem_valid=0 SHALL be ignored.
REQ-030 req_valid while req_ready=0 SHALL be ignored (no queueing).

Reset
REQ-031 reset=0 SHALL immediately, asynchronously force state IDLE and all outputs to 0 except req_ready=1, including mid-MEM or mid-WB; no pending request survives.
REQ-032 First accept is possible on the first rising edge with reset=1.

Verification
REQ-033 LW base=0x100 offset=4, mem_ready same cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x104, wb_enable at N+2, wb_data=0xDEADBEEF.
REQ-034 LB ea=0x203, mem_rdata=0x80123456 -> wb_data=0xFFFFFF80; LBU same -> 0x00000080; LH ea=0x202 -> 0xFFFF8012.
REQ-035 SH ea=0x302 store_data=0x0000ABCD, mem_ready delayed 3 cycles -> mem_addr=0x300, mem_wstrb=4'b1100, mem_wdata=0xABCDABCD held stable all 3 cycles, no wb_enable.
REQ-036 LW ea=0x101, and funct3=011 -> fault pulse one cycle, mem_valid never asserted, req_ready stays 1.
REQ-037 Load rd=0 -> memory access completes, wb_enable stays 0, unit returns to IDLE.
REQ-038 reset=0 asserted mid-MEM without clock edge -> mem_valid=0 immediately; after release new LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I load or store at a time, issues a single
// word-aligned memory request, and drives the register-file write port for loads.
module load_store_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] offset,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_wstrb,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata,
    output logic            wb_enable,
    output logic [4:0]      wb_reg,
    output logic [XLEN-1:0] wb_data,
    output logic            fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t          state_q;
    logic            req_ready_q;
    logic            mem_valid_q;
    logic [XLEN-1:0] mem_addr_q;
    logic            mem_we_q;
    logic [3:0]      mem_wstrb_q;
    logic [31:0]     mem_wdata_q;
    logic            wb_enable_q;
    logic [4:0]      wb_reg_q;
    logic [XLEN-1:0] wb_data_q;
    logic            fault_q;

    // Request attributes kept for the load extraction in MEM
    logic [2:0]      funct3_q;
    logic [1:0]      ea_lo_q;
    logic [4:0]      rd_q;

    // Decode of the incoming request
    logic [XLEN-1:0] ea_c;
    logic            legal_c;
    logic            misaligned_c;
    logic [3:0]      wstrb_c;
    logic [31:0]     wdata_c;

    // Lane extraction of the returned read word
    logic [31:0]     lane_c;
    logic [XLEN-1:0] load_val_c;

    // Effective address, legality, alignment and store lane formatting
    always_comb begin
        ea_c    = base + offset;
        legal_c = 1'b0;
        case ({is_store, funct3})
            4'b0_000, 4'b0_001, 4'b0_010, 4'b0_100, 4'b0_101,
            4'b1_000, 4'b1_001, 4'b1_010: legal_c = 1'b1;
            default:                      legal_c = 1'b0;
        endcase
        misaligned_c = ((funct3[1:0] == 2'b01) && ea_c[0]) ||
                       ((funct3[1:0] == 2'b10) && (ea_c[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                wstrb_c = 4'b0001 << ea_c[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb_c = 4'b0011 << ea_c[1:0];
                wdata_c = {2{store_data[15:0]}};
            end
            default: begin
                wstrb_c = 4'b1111;
                wdata_c = store_data[31:0];
            end
        endcase
    end

    // Select the addressed byte/half of the read word and extend it
    always_comb begin
        lane_c = mem_rdata >> {ea_lo_q, 3'b000};
        case (funct3_q)
            3'b000:  load_val_c = {{(XLEN-8){lane_c[7]}}, lane_c[7:0]};
            3'b001:  load_val_c = {{(XLEN-16){lane_c[15]}}, lane_c[15:0]};
            3'b100:  load_val_c = {{(XLEN-8){1'b0}}, lane_c[7:0]};
            3'b101:  load_val_c = {{(XLEN-16){1'b0}}, lane_c[15:0]};
            default: load_val_c = XLEN'(mem_rdata);
        endcase
    end

    // Control FSM with all outputs registered; reset clears any in-flight access
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'd0;
            wb_enable_q <= 1'b0;
            wb_reg_q    <= 5'd0;
            wb_data_q   <= '0;
            fault_q     <= 1'b0;
            funct3_q    <= 3'd0;
            ea_lo_q     <= 2'd0;
            rd_q        <= 5'd0;
        end else begin
            fault_q     <= 1'b0;
            wb_enable_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        if (!legal_c || misaligned_c) begin
                            fault_q <= 1'b1;
                        end else begin
                            state_q     <= S_MEM;
                            req_ready_q <= 1'b0;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {ea_c[XLEN-1:2], 2'b00};
                            mem_we_q    <= is_store;
                            mem_wstrb_q <= is_store ? wstrb_c : 4'b0000;
                            mem_wdata_q <= is_store ? wdata_c : 32'd0;
                            funct3_q    <= funct3;
                            ea_lo_q     <= ea_c[1:0];
                            rd_q        <= rd;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        mem_wdata_q <= 32'd0;
                        if (mem_we_q) begin
                            state_q     <= S_IDLE;
                            req_ready_q <= 1'b1;
                        end else begin
                            state_q     <= S_WB;
                            wb_enable_q <= (rd_q != 5'd0);
                            wb_reg_q    <= rd_q;
                            wb_data_q   <= load_val_c;
                        end
                    end
                end
                S_WB: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_enable = wb_enable_q;
    assign wb_reg    = wb_reg_q;
    assign wb_data   = wb_data_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized transactions
// checked against a byte-lane reference model.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        fault;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.XLEN(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .base       (base),
        .offset     (offset),
        .store_data (store_data),
        .rd         (rd),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wb_enable  (wb_enable),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .fault      (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive junk on the request port while the unit is busy; it must be ignored
    task automatic junk_req();
        req_valid  = 1'($urandom % 2);
        is_store   = 1'($urandom % 2);
        funct3     = 3'($urandom % 8);
        base       = $urandom;
        offset     = $urandom;
        store_data = $urandom;
        rd         = 5'($urandom % 32);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full transaction: drive request, check memory phase and result
    // against the reference model. Called at a point where the unit is idle.
    task automatic do_txn(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] b, input logic [31:0] off,
                          input logic [31:0] sd, input logic [4:0] r,
                          input logic [31:0] rdata, input int dly,
                          output logic [31:0] got);
        logic [31:0] ea;
        bit          legal;
        int          size;
        int          k;
        bit          bad;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
        longint      v;

        ea    = b + off;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        k     = int'(ea % 4);
        bad   = !legal || ((ea % size) != 0);

        exp_strb  = 4'b0000;
        exp_wdata = 32'd0;
        if (st && !bad) begin
            for (int j = 0; j < 4; j++) begin
                if (j >= k && j < k + size) exp_strb[j] = 1'b1;
                exp_wdata[j*8 +: 8] = sd[(j % size)*8 +: 8];
            end
        end

        exp_load = rdata;
        if (size < 4) begin
            v = (longint'(rdata) >> (8 * k)) % (longint'(1) << (8 * size));
            if (!f3[2] && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            exp_load = 32'(v);
        end

        check({tag, "_ready_before"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        is_store   = st;
        funct3     = f3;
        base       = b;
        offset     = off;
        store_data = sd;
        rd         = r;
        step();
        req_valid  = 1'b0;
        got        = 32'd0;

        if (bad) begin
            mem_ready = 1'b1;
            check({tag, "_fault_pulse"}, 32'(fault), 32'd1);
            check({tag, "_fault_novalid"}, 32'(mem_valid), 32'd0);
            check({tag, "_fault_ready"}, 32'(req_ready), 32'd1);
            step();
            mem_ready = 1'b0;
            check({tag, "_fault_end"}, 32'(fault), 32'd0);
            check({tag, "_fault_novalid2"}, 32'(mem_valid), 32'd0);
            check({tag, "_fault_nowb"}, 32'(wb_enable), 32'd0);
            return;
        end

        for (int i = 0; i <= dly; i++) begin
            check({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
            check({tag, "_mem_addr"}, mem_addr, ea - (ea % 4));
            check({tag, "_mem_we"}, 32'(mem_we), 32'(st));
            check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
            check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
            check({tag, "_busy"}, 32'(req_ready), 32'd0);
            check({tag, "_nofault"}, 32'(fault), 32'd0);
            check({tag, "_nowb_mem"}, 32'(wb_enable), 32'd0);
            mem_ready = (i == dly);
            mem_rdata = (i == dly) ? rdata : $urandom;
            junk_req();
            step();
        end
        mem_ready = 1'b0;

        if (st) begin
            req_valid = 1'b0;
            check({tag, "_st_done_ready"}, 32'(req_ready), 32'd1);
            check({tag, "_st_done_valid"}, 32'(mem_valid), 32'd0);
            check({tag, "_st_nowb"}, 32'(wb_enable), 32'd0);
        end else begin
            check({tag, "_wb_enable"}, 32'(wb_enable), 32'(r != 5'd0));
            check({tag, "_wb_reg"}, 32'(wb_reg), 32'(r));
            check({tag, "_wb_data"}, wb_data, exp_load);
            check({tag, "_wb_busy"}, 32'(req_ready), 32'd0);
            check({tag, "_wb_novalid"}, 32'(mem_valid), 32'd0);
            got = wb_data;
            junk_req();
            step();
            req_valid = 1'b0;
            check({tag, "_wb_drop"}, 32'(wb_enable), 32'd0);
            check({tag, "_ld_done_ready"}, 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] got;
        logic        st;
        logic [2:0]  f3;

        reset      = 1'b0;
        req_valid  = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'd0;
        base       = 32'd0;
        offset     = 32'd0;
        store_data = 32'd0;
        rd         = 5'd0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'd0;

        // Reset state
        #12;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_wb_en", 32'(wb_enable), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_addr", mem_addr, 32'd0);

        // Release away from an edge; the very next rising edge accepts
        @(negedge clock);
        reset = 1'b1;

        do_txn("lw_basic", 1'b0, 3'b010, 32'h100, 32'd4, 32'd0, 5'd5, 32'hDEADBEEF, 0, got);
        check("lw_basic_val", got, 32'hDEADBEEF);
        do_txn("lb_neg", 1'b0, 3'b000, 32'h200, 32'd3, 32'd0, 5'd6, 32'h80123456, 1, got);
        check("lb_neg_val", got, 32'hFFFFFF80);
        do_txn("lbu", 1'b0, 3'b100, 32'h200, 32'd3, 32'd0, 5'd7, 32'h80123456, 0, got);
        check("lbu_val", got, 32'h00000080);
        do_txn("lh_neg", 1'b0, 3'b001, 32'h200, 32'd2, 32'd0, 5'd8, 32'h80123456, 2, got);
        check("lh_neg_val", got, 32'hFFFF8012);
        do_txn("sh_delay", 1'b1, 3'b001, 32'h300, 32'd2, 32'h0000ABCD, 5'd9, 32'd0, 3, got);
        do_txn("lw_misal", 1'b0, 3'b010, 32'h100, 32'd1, 32'd0, 5'd3, 32'd0, 0, got);
        do_txn("f3_011", 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 5'd3, 32'd0, 0, got);
        do_txn("st_f3_100", 1'b1, 3'b100, 32'h40, 32'd0, 32'h12345678, 5'd3, 32'd0, 0, got);
        do_txn("sb_lane2", 1'b1, 3'b000, 32'h402, 32'd0, 32'h000000A5, 5'd1, 32'd0, 1, got);
        do_txn("sw", 1'b1, 3'b010, 32'h500, 32'hFFFFFFFC, 32'hCAFEF00D, 5'd1, 32'd0, 0, got);
        do_txn("ld_rd0", 1'b0, 3'b010, 32'h600, 32'd0, 32'd0, 5'd0, 32'h13572468, 1, got);
        do_txn("lhu", 1'b0, 3'b101, 32'h700, 32'd2, 32'd0, 5'd31, 32'hF00D1234, 0, got);
        check("lhu_val", got, 32'h0000F00D);

        // Asynchronous reset in the middle of a memory access
        req_valid = 1'b1;
        is_store  = 1'b0;
        funct3    = 3'b010;
        base      = 32'h800;
        offset    = 32'd8;
        rd        = 5'd4;
        step();
        req_valid = 1'b0;
        check("midmem_valid", 32'(mem_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(mem_valid), 32'd0);
        check("arst_ready", 32'(req_ready), 32'd1);
        check("arst_addr", mem_addr, 32'd0);
        check("arst_wb_en", 32'(wb_enable), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("post_rst_valid", 32'(mem_valid), 32'd0);
        check("post_rst_nowb", 32'(wb_enable), 32'd0);
        do_txn("lw_after_rst", 1'b0, 3'b010, 32'h900, 32'd4, 32'd0, 5'd10, 32'h0BADCAFE, 0, got);
        check("lw_after_rst_val", got, 32'h0BADCAFE);

        // Randomized transactions
        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            do_txn("rand", st, f3, $urandom, 32'($signed(12'($urandom))), $urandom,
                   5'($urandom % 32), $urandom, int'($urandom % 4), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
